// File: rtl/pulsadores_pkg.sv
// Shared definitions for the push-button conditioning block: repeat FSM
// encoding, button indices and default timing parameters.
package pulsadores_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    REPITE = 2'd2
  } rep_state_e;

  localparam int ARRIBA    = 0;
  localparam int ABAJO     = 1;
  localparam int IZQ       = 2;
  localparam int DER       = 3;
  localparam int CENTRO    = 4;
  localparam int N_BOTONES = 5;

  // 100 MHz clock: 10 ms debounce, 0.5 s to first repeat, 0.2 s between repeats
  localparam int DEF_DEBOUNCE_CYC  = 1_000_000;
  localparam int DEF_REPEAT_DELAY  = 50_000_000;
  localparam int DEF_REPEAT_PERIOD = 20_000_000;

endpackage

// File: rtl/canal_boton.sv
// One button channel: two-flop synchronizer, debounce filter, press edge
// detector and, when REPITE_EN is set, an auto-repeat FSM.
module canal_boton
  import pulsadores_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter bit REPITE_EN     = 1'b0
) (
  input  logic clk,
  input  logic Reset,
  input  logic pin_i,
  output logic pulso_o,
  output logic nivel_o
);

  localparam int CW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_FIN = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_FIN = RW'(REPEAT_PERIOD - 1);

  logic          s1_q, s2_q;
  logic          est_q, est_d, est_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  rep_state_e    state_q, state_d;
  logic          press;

  // A level is accepted only after DEBOUNCE_CYC consecutive differing samples
  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q;
    if (s2_q == est_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_FIN) begin
      est_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      est_q      <= 1'b0;
      est_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= pin_i;
      s2_q       <= s1_q;
      est_q      <= est_d;
      est_prev_q <= est_q;
      cnt_q      <= cnt_d;
    end
  end

  assign press   = est_q & ~est_prev_q;
  assign nivel_o = est_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Channels without repeat never leave IDLE, so they only pass the press
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (press && REPITE_EN) begin
          state_d = ESPERA;
          rcnt_d  = '0;
        end
      end
      ESPERA: begin
        if (!est_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DLY_FIN) begin
          state_d = REPITE;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      REPITE: begin
        if (!est_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PER_FIN) begin
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    pulso_o = 1'b0;
    case (state_q)
      IDLE:    pulso_o = press;
      ESPERA:  pulso_o = est_q && (rcnt_q == DLY_FIN);
      REPITE:  pulso_o = est_q && (rcnt_q == PER_FIN);
      default: pulso_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/acond_pulsadores.sv
// Conditions the five raw push buttons into clean press pulses and debounced
// levels, with direction arbitration and registered outputs.
module acond_pulsadores
  import pulsadores_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       push_arriba,
  input  logic       push_abajo,
  input  logic       push_izquierda,
  input  logic       push_derecha,
  input  logic       push_centro,
  output logic       p_arriba,
  output logic       p_abajo,
  output logic       p_izquierda,
  output logic       p_derecha,
  output logic       p_centro,
  output logic [4:0] nivel
);

  logic [N_BOTONES-1:0] pin, crudo, est;
  logic [N_BOTONES-1:0] p_d, p_q, nivel_q;

  assign pin = {push_centro, push_derecha, push_izquierda, push_abajo, push_arriba};

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
    canal_boton #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPITE_EN    ((i == ARRIBA) || (i == ABAJO))
    ) u_canal (
      .clk    (clk),
      .Reset  (Reset),
      .pin_i  (pin[i]),
      .pulso_o(crudo[i]),
      .nivel_o(est[i])
    );
  end

  // Lower-priority directions are dropped outright when a higher one fires
  always_comb begin
    p_d         = crudo;
    p_d[ABAJO]  = crudo[ABAJO] & ~crudo[ARRIBA];
    p_d[IZQ]    = crudo[IZQ] & ~(crudo[ARRIBA] | crudo[ABAJO]);
    p_d[DER]    = crudo[DER] & ~(crudo[ARRIBA] | crudo[ABAJO] | crudo[IZQ]);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      p_q     <= '0;
      nivel_q <= '0;
    end else begin
      p_q     <= p_d;
      nivel_q <= est;
    end
  end

  assign p_arriba    = p_q[ARRIBA];
  assign p_abajo     = p_q[ABAJO];
  assign p_izquierda = p_q[IZQ];
  assign p_derecha   = p_q[DER];
  assign p_centro    = p_q[CENTRO];
  assign nivel       = nivel_q;

endmodule

// File: tb/tb_acond_pulsadores.sv
// Self-checking bench for acond_pulsadores against a cycle-level behavioural
// model of debounce, press, repeat schedule and direction priority.
module tb_acond_pulsadores;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic       clk = 1'b0;
  logic       Reset;
  logic [4:0] pins;
  logic       pArriba, pAbajo, pIzquierda, pDerecha, pCentro;
  logic [4:0] nivel;
  logic [9:0] obs;
  logic [9:0] expV;

  int  nCompared;
  int  nMismatched;

  // Model state: debounced level, its previous value, run of differing
  // samples, the pin two edges back, and cycles since the press pulse
  bit  estM[5];
  bit  estPrevM[5];
  int  runM[5];
  bit  h1[5];
  bit  h2[5];
  int  ageM[5];

  always #5 clk = ~clk;

  acond_pulsadores #(
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .push_arriba   (pins[0]),
    .push_abajo    (pins[1]),
    .push_izquierda(pins[2]),
    .push_derecha  (pins[3]),
    .push_centro   (pins[4]),
    .p_arriba      (pArriba),
    .p_abajo       (pAbajo),
    .p_izquierda   (pIzquierda),
    .p_derecha     (pDerecha),
    .p_centro      (pCentro),
    .nivel         (nivel)
  );

  assign obs = {nivel, pCentro, pDerecha, pIzquierda, pAbajo, pArriba};

  task automatic modelStep(input logic [4:0] pinV, input logic rst);
    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] p;
    if (rst) begin
      for (int ch = 0; ch < 5; ch++) begin
        estM[ch] = 0; estPrevM[ch] = 0; runM[ch] = 0;
        h1[ch] = 0; h2[ch] = 0; ageM[ch] = 0;
      end
      expV = '0;
      return;
    end
    for (int ch = 0; ch < 5; ch++) begin
      lvl[ch] = estM[ch];
      raw[ch] = 1'b0;
      if (estM[ch]) begin
        if (!estPrevM[ch]) begin
          raw[ch]  = 1'b1;
          ageM[ch] = 0;
        end else begin
          ageM[ch]++;
          if (ch <= 1 && (ageM[ch] == DLY ||
              (ageM[ch] > DLY && (ageM[ch] - DLY) % PER == 0)))
            raw[ch] = 1'b1;
        end
      end
    end
    p[0] = raw[0];
    p[1] = raw[1] && !raw[0];
    p[2] = raw[2] && !raw[1] && !raw[0];
    p[3] = raw[3] && !raw[2] && !raw[1] && !raw[0];
    p[4] = raw[4];
    expV = {lvl, p};
    for (int ch = 0; ch < 5; ch++) begin
      estPrevM[ch] = estM[ch];
      if (h2[ch] != estM[ch]) begin
        runM[ch]++;
        if (runM[ch] == DEB) begin
          estM[ch] = h2[ch];
          runM[ch] = 0;
        end
      end else begin
        runM[ch] = 0;
      end
      h2[ch] = h1[ch];
      h1[ch] = pinV[ch];
    end
  endtask

  task automatic tick(input logic [4:0] pinV, input logic rst);
    pins  = pinV;
    Reset = rst;
    @(posedge clk);
    modelStep(pinV, rst);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 30; i++) tick(5'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(5'($urandom_range(0, 31)), 1'b1);
      nCompared++;
      if (obs !== 10'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset cycle %0d: got %b expected %b", i, obs, 10'b0);
      end
    end
    flush();
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int pulseAt = -1;
    for (int i = 0; i < 30; i++) begin
      tick((i < 10) ? 5'b00100 : 5'b0, 1'b0);
      nCompared++;
      if (obs !== expV) begin
        nMismatched++;
        $display("[TB] FAIL clean_press edge %0d: got %b expected %b", i, obs, expV);
      end
      if (pIzquierda) begin pulses++; pulseAt = i; end
      if (i == 5 || i == 6 || i == 15 || i == 16) begin
        nCompared++;
        if (nivel[2] !== ((i == 6 || i == 15) ? 1'b1 : 1'b0)) begin
          nMismatched++;
          $display("[TB] FAIL clean_press_nivel edge %0d: got %b", i, nivel[2]);
        end
      end
    end
    nCompared++;
    if (pulses != 1 || pulseAt != 6) begin
      nMismatched++;
      $display("[TB] FAIL clean_press_pulse: got %0d pulses at %0d, expected 1 at 6", pulses, pulseAt);
    end
    flush();
  endtask

  task automatic test_bounce();
    bit vals[6]   = '{1, 1, 0, 1, 1, 0};
    int widths[6] = '{1, 2, 1, 2, 1, 3};
    int e = 0;
    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < widths[k]; w++) begin
        tick({1'b0, vals[k], 3'b000}, 1'b0);
        nCompared++;
        if (obs !== expV || pDerecha !== 1'b0 || nivel[3] !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL bounce edge %0d: got %b expected %b", e, obs, expV);
        end
        e++;
      end
    end
    for (int i = 0; i < 15; i++) begin
      tick(5'b0, 1'b0);
      nCompared++;
      if (obs !== expV || pDerecha !== 1'b0 || nivel[3] !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL bounce_tail edge %0d: got %b expected %b", e + i, obs, expV);
      end
    end
    flush();
  endtask

  task automatic runHeld(input string name, input logic [4:0] pinV, input int chk,
                         input int expCount, input int expFirst, output int count);
    int first = -1;
    count = 0;
    for (int i = 0; i < 80; i++) begin
      tick((i < 60) ? pinV : 5'b0, 1'b0);
      nCompared++;
      if (obs !== expV) begin
        nMismatched++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", name, i, obs, expV);
      end
      if (obs[chk]) begin
        if (first < 0) first = i;
        count++;
      end
    end
    nCompared++;
    if (count != expCount || (expCount > 0 && first != expFirst)) begin
      nMismatched++;
      $display("[TB] FAIL %s_count: got %0d pulses first at %0d, expected %0d first at %0d",
               name, count, first, expCount, expFirst);
    end
    flush();
  endtask

  task automatic test_auto_repeat();
    int c;
    runHeld("auto_repeat", 5'b00001, 0, 6, 6, c);
  endtask

  task automatic test_simultaneous();
    int cA, cB;
    runHeld("simul_arriba", 5'b00011, 0, 6, 6, cA);
    runHeld("simul_abajo", 5'b00011, 1, 0, -1, cB);
  endtask

  task automatic test_centro_no_repeat();
    int c;
    runHeld("centro", 5'b10000, 4, 1, 6, c);
  endtask

  task automatic test_reset_mid_repeat();
    int expEdges[8] = '{6, 26, 38, 58, 66, 74, 82, 90};
    int got[$];
    for (int i = 0; i < 100; i++) begin
      tick((i < 90) ? 5'b00010 : 5'b0, (i == 30 || i == 31));
      nCompared++;
      if (obs !== expV) begin
        nMismatched++;
        $display("[TB] FAIL reset_mid_repeat edge %0d: got %b expected %b", i, obs, expV);
      end
      if (pAbajo) got.push_back(i);
    end
    nCompared++;
    if (got.size() != 8) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_repeat_count: got %0d expected 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        nCompared++;
        if (got[k] != expEdges[k]) begin
          nMismatched++;
          $display("[TB] FAIL reset_mid_repeat_edge%0d: got %0d expected %0d", k, got[k], expEdges[k]);
        end
      end
    end
    flush();
  endtask

  task automatic test_random();
    int   holdLeft[5] = '{0, 0, 0, 0, 0};
    logic [4:0] cur = '0;
    logic rst;
    for (int i = 0; i < 2000; i++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (holdLeft[ch] == 0) begin
          cur[ch]      = 1'($urandom_range(0, 1));
          holdLeft[ch] = $urandom_range(1, 40);
        end
        holdLeft[ch]--;
      end
      rst = ($urandom_range(0, 249) == 0);
      tick(cur, rst);
      nCompared++;
      if (obs !== expV) begin
        nMismatched++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obs, expV);
      end
      nCompared++;
      if ($countones(obs[3:0]) > 1) begin
        nMismatched++;
        $display("[TB] FAIL random_onehot cycle %0d: got %b expected at most one", i, obs[3:0]);
      end
    end
    flush();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    pins        = '0;
    Reset       = 1'b1;
    expV        = '0;
    modelStep(5'b0, 1'b1);
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_centro_no_repeat();
    test_reset_mid_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
